// File: rtl/red_iterativa_der_izq_pkg.sv
// rtl/red_iterativa_der_izq_pkg.sv - shared width default and cell-mode enum for the iterative comparator
package red_iterativa_der_izq_pkg;

   localparam int K_DEFAULT = 4;

   // SIGN_CELL swaps the "A wins" term so the MSB cell reads as a two's-complement sign bit
   typedef enum logic {
      UNSIGNED_CELL = 1'b0,
      SIGN_CELL     = 1'b1
   } cell_mode_e;

endpackage

// File: rtl/red_iterativa_der_izq_if.sv
// rtl/red_iterativa_der_izq_if.sv - operand/result bundle between stimulus source and comparator
interface red_iterativa_der_izq_if
   import red_iterativa_der_izq_pkg::*;
   #(parameter int K = K_DEFAULT);

   logic [K-1:0] A;
   logic [K-1:0] B;
   logic         valid_in;
   logic [K-1:0] N;
   logic         Z;
   logic         valid_out;

   modport master (output A, B, valid_in, input N, Z, valid_out);
   modport slave  (input A, B, valid_in, output N, Z, valid_out);

endinterface

// File: rtl/red_iterativa_der_izq_celda.sv
// rtl/red_iterativa_der_izq_celda.sv - one-bit comparator cell merging its bit pair with the lower verdict
module celda_comparadora
   import red_iterativa_der_izq_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       n_in,
   input  cell_mode_e mode,
   output logic       n_out
);

   logic wins;
   logic same;

   // A differing bit decides outright; equal bits pass the lower verdict through
   assign wins  = (mode == SIGN_CELL) ? (~a & b) : (a & ~b);
   assign same  = ~(a ^ b);
   assign n_out = wins | (same & n_in);

endmodule

// File: rtl/red_iterativa_der_izq.sv
// rtl/red_iterativa_der_izq.sv - registered right-to-left chain comparator; RED_ITERATIVA_SIGNED_EN selects signed operands
module red_iterativa_der_izq
   import red_iterativa_der_izq_pkg::*;
   #(parameter int K = K_DEFAULT)
(
   input  logic                    clk,
   input  logic                    reset,
   red_iterativa_der_izq_if.slave  bus
);

   logic [K:0]   chain;
   logic [K-1:0] n_reg;
   logic         z_reg;
   logic         valid_reg;

   assign chain[0] = 1'b0;

   for (genvar i = 0; i < K; i++) begin : g_cell
`ifdef RED_ITERATIVA_SIGNED_EN
      localparam cell_mode_e MODE = (i == K - 1) ? SIGN_CELL : UNSIGNED_CELL;
`else
      localparam cell_mode_e MODE = UNSIGNED_CELL;
`endif
      celda_comparadora u_celda (
         .a     (bus.A[i]),
         .b     (bus.B[i]),
         .n_in  (chain[i]),
         .mode  (MODE),
         .n_out (chain[i+1])
      );
   end

   // Results only move on a valid sample; otherwise the last verdict stays on display
   always_ff @(posedge clk) begin
      if (reset) begin
         n_reg     <= '0;
         z_reg     <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         valid_reg <= bus.valid_in;
         if (bus.valid_in) begin
            n_reg <= chain[K:1];
            z_reg <= chain[K];
         end
      end
   end

   assign bus.N         = n_reg;
   assign bus.Z         = z_reg;
   assign bus.valid_out = valid_reg;

endmodule

// File: tb/tb_red_iterativa_der_izq.sv
// tb/tb_red_iterativa_der_izq.sv - scoreboard bench for K=4 and K=1 comparators against an arithmetic model
module tb_red_iterativa_der_izq;

`ifdef RED_ITERATIVA_SIGNED_EN
   localparam bit SIGNED = 1'b1;
`else
   localparam bit SIGNED = 1'b0;
`endif

   typedef struct {
      logic [3:0] n4;
      logic       z4;
      logic       n1;
      logic       z1;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t sb_q[$];

   red_iterativa_der_izq_if #(.K(4)) bus4 ();
   red_iterativa_der_izq_if #(.K(1)) bus1 ();

   red_iterativa_der_izq #(.K(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
   red_iterativa_der_izq #(.K(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   always #5 clk = ~clk;

   // N[i] is simply "low i+1 bits of A exceed those of B", read as signed at the top bit when enabled
   function automatic logic [3:0] ref_vec(input logic [3:0] a, input logic [3:0] b, input int k);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < k; i++) begin
         int w;
         int ua;
         int ub;
         w  = i + 1;
         ua = int'(a) & ((1 << w) - 1);
         ub = int'(b) & ((1 << w) - 1);
         if (SIGNED && i == k - 1) begin
            if (ua >= (1 << i)) ua = ua - (1 << w);
            if (ub >= (1 << i)) ub = ub - (1 << w);
         end
         n[i] = (ua > ub);
      end
      return n;
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic v, input logic r);
      exp_t e;
      logic [3:0] v4;
      logic [3:0] v1;
      @(negedge clk);
      bus4.A        = a;
      bus4.B        = b;
      bus4.valid_in = v;
      bus1.A        = a[0];
      bus1.B        = b[0];
      bus1.valid_in = v;
      reset         = r;
      if (v && !r) begin
         v4   = ref_vec(a, b, 4);
         v1   = ref_vec(a, b, 1);
         e.n4 = v4;
         e.z4 = v4[3];
         e.n1 = v1[0];
         e.z1 = v1[0];
         sb_q.push_back(e);
      end
   endtask

   // Monitor: after every edge, either a fresh result is due, reset cleared everything, or outputs hold
   initial begin : monitor
      exp_t hold;
      exp_t cur;
      logic rst_edge;
      hold = '{n4: 4'b0, z4: 1'b0, n1: 1'b0, z1: 1'b0};
      forever begin
         @(posedge clk);
         rst_edge = reset;
         #1;
         if (rst_edge) begin
            hold = '{n4: 4'b0, z4: 1'b0, n1: 1'b0, z1: 1'b0};
            check("reset_valid_out", {3'b0, bus4.valid_out}, 4'b0);
            check("reset_valid_out_k1", {3'b0, bus1.valid_out}, 4'b0);
            cur = hold;
         end else if (sb_q.size() > 0) begin
            cur  = sb_q.pop_front();
            hold = cur;
            check("valid_out", {3'b0, bus4.valid_out}, 4'b1);
            check("valid_out_k1", {3'b0, bus1.valid_out}, 4'b1);
         end else begin
            cur = hold;
            check("idle_valid_out", {3'b0, bus4.valid_out}, 4'b0);
            check("idle_valid_out_k1", {3'b0, bus1.valid_out}, 4'b0);
         end
         check("N", bus4.N, cur.n4);
         check("Z", {3'b0, bus4.Z}, {3'b0, cur.z4});
         check("N_k1", {3'b0, bus1.N}, {3'b0, cur.n1});
         check("Z_k1", {3'b0, bus1.Z}, {3'b0, cur.z1});
      end
   end

   initial begin : stimulus
      bus4.A = '0; bus4.B = '0; bus4.valid_in = 1'b0;
      bus1.A = '0; bus1.B = '0; bus1.valid_in = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);

      apply(4'b0000, 4'b0000, 1'b0, 1'b0);
      apply(4'b0101, 4'b0011, 1'b1, 1'b0);
      apply(4'b1010, 4'b1010, 1'b1, 1'b0);
      apply(4'b0011, 4'b0100, 1'b1, 1'b0);
      apply(4'b1000, 4'b0111, 1'b1, 1'b0);
      apply(4'b0001, 4'b0000, 1'b1, 1'b0);
      apply(4'b0000, 4'b0001, 1'b1, 1'b0);
      apply(4'b1111, 4'b1111, 1'b0, 1'b0);
      apply(4'b0101, 4'b0011, 1'b1, 1'b1);
      apply(4'b0101, 4'b0011, 1'b0, 1'b0);
      apply(4'b1111, 4'b0000, 1'b0, 1'b0);
      apply(4'b0110, 4'b0010, 1'b1, 1'b0);
      apply(4'b0110, 4'b0010, 1'b1, 1'b1);
      apply(4'b0000, 4'b0000, 1'b0, 1'b0);

      for (int i = 0; i < 300; i++) begin
         apply(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 31) == 0));
      end

      apply(4'b0000, 4'b0000, 1'b0, 1'b0);
      apply(4'b0000, 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      check("scoreboard_drained", 4'(sb_q.size()), 4'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
